// File: rtl/dec_pkg.sv
// Shared types and helpers for the dec_scan decoder family.
package dec_pkg;

  // Top-level operating states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // Output width of an N-to-2^N decoder.
  function automatic int ONEHOT_W(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/dec_onehot.sv
// Purely combinational N-to-2^N one-hot decoder with enable.
module dec_onehot
  import dec_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]           sel,
  input  logic                   en,
  output logic [ONEHOT_W(N)-1:0] dec
);

  // Drive the selected bit when enabled, all zeros otherwise.
  always_comb begin
    // NOTE: assigning a default before the conditional keeps every path
    // driven, so no latch is inferred for the bits not selected.
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with direct and scanning modes. In scan mode
// the index walks every output, holding each for dwell+1 cycles, and pulses
// wrap whenever it rolls over from the last output back to zero.
module dec_scan
  import dec_pkg::*;
#(
  parameter int N       = 3,
  parameter int DWELL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   mode,
  input  logic                   start,
  input  logic                   stop,
  input  logic [N-1:0]           a,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [ONEHOT_W(N)-1:0] out,
  output logic [N-1:0]           idx,
  output logic                   busy,
  output logic                   wrap
);

  state_t               state_q, state_d;
  logic [N-1:0]         idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 wrap_d;
  logic [N-1:0]         dec_sel;
  logic                 dec_en;
  logic [ONEHOT_W(N)-1:0] dec_out;

  // The decoder produces the next output pattern; it is registered below.
  dec_onehot #(.N(N)) u_onehot (
    .sel (dec_sel),
    .en  (dec_en),
    .dec (dec_out)
  );

  // busy comes straight from the state register, so it is registered too.
  assign busy = (state_q != IDLE);

  // Next-state, index, dwell counter and decoder-select computation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    dec_sel = idx;
    dec_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // stop beats start; a paused block does not launch.
        if (start && !stop && en) begin
          state_d = mode ? SCAN : DIRECT;
          idx_d   = a;
          dec_sel = a;
          dec_en  = 1'b1;
          if (mode) begin
            dwell_d = dwell;
            cnt_d   = '0;
          end
        end
      end

      DIRECT: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (en) begin
          idx_d   = a;
          dec_sel = a;
          dec_en  = 1'b1;
        end
      end

      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (en) begin
          dec_en = 1'b1;
          if (out == '0) begin
            // Coming back from a pause: re-present the frozen index first so
            // it still gets its full dwell before advancing.
            dec_sel = idx;
          end else if (cnt_q == dwell_q) begin
            cnt_d   = '0;
            idx_d   = idx + N'(1);
            dec_sel = idx + N'(1);
            wrap_d  = &idx;
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx     <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      out     <= '0;
      wrap    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every register sample the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      idx     <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      out     <= dec_out;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_dec_scan.sv
// Directed bench for dec_scan: an N=3 instance for most scenarios and an
// N=4 instance for the long scan.
module tb_dec_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, mode, start, stop;
  logic [2:0] a;
  logic [3:0] dwell;
  logic [7:0] out;
  logic [2:0] idx;
  logic       busy, wrap;

  logic        start4, stop4;
  logic [3:0]  a4;
  logic [15:0] out4;
  logic [3:0]  idx4;
  logic        busy4, wrap4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dec_scan #(.N(3), .DWELL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start),
    .stop(stop), .a(a), .dwell(dwell), .out(out), .idx(idx),
    .busy(busy), .wrap(wrap)
  );

  dec_scan #(.N(4), .DWELL_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .start(start4),
    .stop(stop4), .a(a4), .dwell(dwell), .out(out4), .idx(idx4),
    .busy(busy4), .wrap(wrap4)
  );

  // Advance one edge and sample just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; start = 1'b0; stop = 1'b0;
    a = '0; dwell = '0; start4 = 1'b0; stop4 = 1'b0; a4 = '0;
    #12;
    total_cnt++;
    if ({out, idx, busy, wrap} !== 13'h0)
      $display("FAIL reset_state: got out=%b idx=%0d busy=%b wrap=%b want all 0", out, idx, busy, wrap);
    else pass_cnt++;
    rst_n = 1'b1;
    cyc();
    total_cnt++;
    if (busy !== 1'b0 || out !== 8'h00)
      $display("FAIL idle_after_reset: got busy=%b out=%b want 0/00000000", busy, out);
    else pass_cnt++;
  endtask

  task automatic test_direct();
    mode = 1'b0; a = 3'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    total_cnt++;
    if (out !== 8'b0000_0001 || busy !== 1'b1)
      $display("FAIL direct_start: got out=%b busy=%b want 00000001/1", out, busy);
    else pass_cnt++;
    for (int i = 1; i < 8; i++) begin
      a = 3'(i);
      total_cnt++;
      if (out !== 8'(1 << (i - 1)))
        $display("FAIL direct_latency %0d: got out=%b want %b", i, out, 8'(1 << (i - 1)));
      else pass_cnt++;
      cyc();
      total_cnt++;
      if (out !== 8'(1 << i) || idx !== 3'(i))
        $display("FAIL direct_decode %0d: got out=%b idx=%0d want %b/%0d", i, out, idx, 8'(1 << i), i);
      else pass_cnt++;
    end
    en = 1'b0;
    cyc();
    total_cnt++;
    if (out !== 8'h00 || busy !== 1'b1)
      $display("FAIL direct_en_low: got out=%b busy=%b want 00000000/1", out, busy);
    else pass_cnt++;
    en = 1'b1;
    cyc();
    total_cnt++;
    if (out !== 8'b1000_0000)
      $display("FAIL direct_en_restore: got out=%b want 10000000", out);
    else pass_cnt++;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || out !== 8'h00 || idx !== 3'd7)
      $display("FAIL direct_stop: got busy=%b out=%b idx=%0d want 0/00000000/7", busy, out, idx);
    else pass_cnt++;
  endtask

  task automatic test_scan_wrap();
    logic [2:0] exp_idx;
    logic       exp_wrap;
    mode = 1'b1; a = 3'd6; dwell = 4'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    // Each index holds two cycles: 6,6,7,7,0(wrap),0,1,1,... period 16.
    for (int c = 0; c <= 20; c++) begin
      exp_idx  = 3'((6 + c / 2) % 8);
      exp_wrap = (c == 4) || (c == 20);
      total_cnt++;
      if (out !== 8'(1 << exp_idx) || idx !== exp_idx || wrap !== exp_wrap || busy !== 1'b1)
        $display("FAIL scan_seq c=%0d: got out=%b idx=%0d wrap=%b busy=%b want %b/%0d/%b/1",
                 c, out, idx, wrap, busy, 8'(1 << exp_idx), exp_idx, exp_wrap);
      else pass_cnt++;
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || out !== 8'h00 || wrap !== 1'b0 || idx !== 3'd0)
      $display("FAIL scan_stop: got busy=%b out=%b wrap=%b idx=%0d want 0/00000000/0/0", busy, out, wrap, idx);
    else pass_cnt++;
  endtask

  task automatic test_en_drop();
    mode = 1'b1; a = 3'd0; dwell = 4'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    total_cnt++;
    if (out !== 8'b0000_1000 || idx !== 3'd3)
      $display("FAIL drop_pre: got out=%b idx=%0d want 00001000/3", out, idx);
    else pass_cnt++;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      total_cnt++;
      if (out !== 8'h00 || idx !== 3'd3 || busy !== 1'b1)
        $display("FAIL drop_frozen %0d: got out=%b idx=%0d busy=%b want 00000000/3/1", k, out, idx, busy);
      else pass_cnt++;
    end
    en = 1'b1;
    cyc();
    total_cnt++;
    if (out !== 8'b0000_1000 || idx !== 3'd3)
      $display("FAIL drop_restore: got out=%b idx=%0d want 00001000/3", out, idx);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (out !== 8'b0001_0000 || idx !== 3'd4)
      $display("FAIL drop_resume: got out=%b idx=%0d want 00010000/4", out, idx);
    else pass_cnt++;
    cyc(); cyc(); cyc();
    en = 1'b0;
    cyc();
    total_cnt++;
    if (out !== 8'h00 || wrap !== 1'b0 || idx !== 3'd7)
      $display("FAIL wrap_pause: got out=%b wrap=%b idx=%0d want 00000000/0/7", out, wrap, idx);
    else pass_cnt++;
    en = 1'b1;
    cyc();
    total_cnt++;
    if (out !== 8'b1000_0000 || wrap !== 1'b0)
      $display("FAIL wrap_restore: got out=%b wrap=%b want 10000000/0", out, wrap);
    else pass_cnt++;
    cyc();
    total_cnt++;
    if (out !== 8'b0000_0001 || wrap !== 1'b1)
      $display("FAIL wrap_pending: got out=%b wrap=%b want 00000001/1", out, wrap);
    else pass_cnt++;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_start_stop();
    mode = 1'b0; a = 3'd2; start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || out !== 8'h00)
      $display("FAIL start_stop_same: got busy=%b out=%b want 0/00000000", busy, out);
    else pass_cnt++;
    start = 1'b1;
    cyc();
    start = 1'b0;
    total_cnt++;
    if (out !== 8'b0000_0100)
      $display("FAIL direct_again: got out=%b want 00000100", out);
    else pass_cnt++;
    mode = 1'b1; a = 3'd5; dwell = 4'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    total_cnt++;
    if (out !== 8'b0010_0000 || busy !== 1'b1)
      $display("FAIL busy_start_ignored: got out=%b busy=%b want 00100000/1", out, busy);
    else pass_cnt++;
    a = 3'd1;
    cyc();
    total_cnt++;
    if (out !== 8'b0000_0010 || idx !== 3'd1)
      $display("FAIL still_direct: got out=%b idx=%0d want 00000010/1", out, idx);
    else pass_cnt++;
    en = 1'b0; stop = 1'b1;
    cyc();
    stop = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || out !== 8'h00)
      $display("FAIL stop_en_low: got busy=%b out=%b want 0/00000000", busy, out);
    else pass_cnt++;
    en = 1'b1;
  endtask

  task automatic test_n4_scan();
    int wraps = 0;
    mode = 1'b1; a4 = 4'd0; dwell = 4'd0; start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    for (int c = 0; c < 48; c++) begin
      if (wrap4) wraps++;
      total_cnt++;
      if (out4 !== 16'(1 << (c % 16)) || !$onehot(out4) || wrap4 !== (c == 16 || c == 32))
        $display("FAIL n4_scan c=%0d: got out=%h wrap=%b want %h/%b",
                 c, out4, wrap4, 16'(1 << (c % 16)), (c == 16 || c == 32));
      else pass_cnt++;
      cyc();
    end
    total_cnt++;
    if (wraps != 2)
      $display("FAIL n4_wrap_count: got %0d want 2", wraps);
    else pass_cnt++;
    stop4 = 1'b1;
    cyc();
    stop4 = 1'b0;
    total_cnt++;
    if (busy4 !== 1'b0 || out4 !== 16'h0)
      $display("FAIL n4_stop: got busy=%b out=%h want 0/0000", busy4, out4);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_scan();
    mode = 1'b1; a = 3'd2; dwell = 4'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    total_cnt++;
    if (busy !== 1'b1 || out !== 8'b0000_0100)
      $display("FAIL mid_scan_pre: got busy=%b out=%b want 1/00000100", busy, out);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out, idx, busy, wrap} !== 13'h0)
      $display("FAIL reset_async: got out=%b idx=%0d busy=%b wrap=%b want all 0", out, idx, busy, wrap);
    else pass_cnt++;
    cyc();
    rst_n = 1'b1;
    cyc();
    total_cnt++;
    if (busy !== 1'b0 || out !== 8'h00)
      $display("FAIL reset_idle: got busy=%b out=%b want 0/00000000", busy, out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_direct();
    test_scan_wrap();
    test_en_drop();
    test_start_stop();
    test_n4_scan();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dec_scan.md
# dec_scan

Parametrised, registered N-to-2^N one-hot decoder with enable, the successor to the fixed 3-to-8 combinational decoder. It has two modes. In direct mode it decodes the select input every cycle. In scan mode an internal index walks all 2^N outputs, holding each for a programmable dwell, and flags every wrap-around. It drives row/channel selects in later assignments, such as display multiplexing and bus arbitration strobes.

## Interface
- `N`, default 3: select width; output width is 2^N.
- `DWELL_W`, default 4: width of the dwell-count input.

- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `en` input, 1: output enable; low pauses the block and forces `out` to zero.
- `mode` input, 1: sampled on `start`; 0 = direct, 1 = scan.
- `start` input, 1: single-cycle request to leave IDLE.
- `stop` input, 1: single-cycle request to return to IDLE.
- `a` input, N: select in direct mode; starting index in scan mode, sampled on `start`.
- `dwell` input, DWELL_W: scan mode holds each output for `dwell`+1 cycles; sampled on `start`.
- `out` output, 2^N: registered one-hot select, or all zeros.
- `idx` output, N: index currently decoded.
- `busy` output, 1: high in DIRECT or SCAN.
- `wrap` output, 1: one-cycle pulse when the scan index wraps from 2^N-1 to 0.

## Operation
- **Reset** (`rst_n` low, asynchronous): state IDLE; `out`=0, `idx`=0, `busy`=0, `wrap`=0; dwell counter=0.
- **States:** IDLE, DIRECT, SCAN.
- **IDLE:**
  - `out`=0.
  - `start` with `mode`=0 → DIRECT.
  - `start` with `mode`=1 → SCAN; `idx`←`a`; latched dwell←`dwell`; dwell counter←0.
- **DIRECT:** each cycle `idx`←`a` and `out`←1<<`a`.
- **SCAN:**
  - `out`=1<<`idx`.
  - Dwell counter increments every cycle.
  - When the counter equals the latched dwell: counter←0 and `idx`←`idx`+1 modulo 2^N.
  - The transition 2^N-1 → 0 asserts `wrap` for exactly the first cycle `idx`=0 is presented.
- **`stop`** in DIRECT or SCAN → IDLE on the next edge. `out`, `busy` and dwell counter clear; `idx` holds its last value.
- **Simultaneous `start` and `stop`:** `stop` wins and the state stays or returns to IDLE.
- **`start` while busy** is ignored. A mode change requires `stop` first.
- **`en` low:**
  - `out`=0 from the next edge.
  - State, `idx`, dwell counter and latched dwell freeze.
  - `wrap` is suppressed and a pending wrap is not lost: it fires when the index actually advances.
  - When `en` returns high, the frozen `out` pattern is restored on the next edge.
  - `stop` is still honoured while `en` is low.
- **`dwell`=0:** the index advances every cycle, giving a full cycle in 2^N clocks.
- **Invariant:** `out` is either zero or exactly one-hot; any other value is an error.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` at edge k: `busy`=1 and the first one-hot pattern appear after edge k.
- Direct mode has one cycle of latency from `a` to `out`.
- Scan period is 2^N·(`dwell`+1) cycles while `en` is high. `wrap` is high in cycle 0 of each period, except the very first period when `start` selects index 0.
- `stop` takes effect after one edge; reset takes effect immediately.

## Structure
- **Package `dec_pkg`:** state enum (IDLE, DIRECT, SCAN) and a `ONEHOT_W(N)` = 2^N constant function.
- **Sub-module `dec_onehot`:** purely combinational N-to-2^N decoder with enable. The top registers its output.
- **Top `dec_scan`:** FSM, index register, dwell counter, output registers. Target 150–250 lines.

## Test plan
1. Reset mid-scan (N=3, `dwell`=2, `rst_n` low for 1 cycle) → outputs immediately 0, IDLE, `busy`=0.
2. Direct mode, `en`=1: `a` steps 0..7 one per cycle → `out` = 00000001..10000000, each one cycle after `a`. Then `en`=0 → `out`=00000000 next cycle, `busy` stays 1.
3. Scan, `a`=6, `dwell`=1:
   - `out` shows 01000000 ×2 cycles, then 10000000 ×2 cycles, then 00000001 with `wrap`=1 for one cycle.
   - Full period = 16 cycles.
4. Scan with `dwell`=0, `en` dropped for 3 cycles at `idx`=3:
   - `out`=0 during the drop, with `idx`=3 frozen.
   - After the drop, `out` resumes at 00001000, then 00010000.
5. `start` and `stop` in the same cycle from IDLE → state stays IDLE. `start` with `mode`=1 while in DIRECT → ignored, `out` keeps tracking `a`.
6. N=4 build, scan `dwell`=0 from 0 → exactly one `wrap` every 16 cycles; `out` one-hot in every non-zero cycle (assertion check).
